// File: rtl/bnd_sched_if.sv
// Bundle of requester, consumer and bnd-unit signals around the bnd scheduler.
// The slave modport is the scheduler; the master modport is everything around it.
interface bnd_sched_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned TAGW = 4
);
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_rdy;
    logic [NREQ*65-1:0]   req_A;
    logic [NREQ*65-1:0]   req_B;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [NREQ-1:0]      flush;
    logic [64:0]          bnd_A;
    logic [64:0]          bnd_B;
    logic [64:0]          bnd_C;
    logic [NREQ-1:0]      res_vld;
    logic [NREQ*65-1:0]   res_data;
    logic [NREQ*TAGW-1:0] res_tag;
    logic [NREQ-1:0]      res_ack;
    logic                 idle;

    modport master (
        output req_vld, req_A, req_B, req_tag, flush, res_ack, bnd_C,
        input  req_rdy, bnd_A, bnd_B, res_vld, res_data, res_tag, idle
    );

    modport slave (
        input  req_vld, req_A, req_B, req_tag, flush, res_ack, bnd_C,
        output req_rdy, bnd_A, bnd_B, res_vld, res_data, res_tag, idle
    );
endinterface

// File: rtl/bnd_sched.sv
// Round-robin scheduler sharing one fixed-latency bnd unit among NREQ requesters.
// Two credits per port bound outstanding work, so each 2-entry result FIFO cannot overflow.
module bnd_sched #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned TAGW = 4,
    parameter int unsigned LAT  = 3
) (
    input logic        clk,
    input logic        rst,
    bnd_sched_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[PW-1:0];
    endfunction

    logic [PW-1:0]                  r_rr;
    logic [NREQ-1:0][1:0]           r_credit;
    logic [64:0]                    r_bnd_a;
    logic [64:0]                    r_bnd_b;
    logic [LAT:0]                   r_stg_vld;
    logic [LAT:0][PW-1:0]           r_stg_port;
    logic [LAT:0][TAGW-1:0]         r_stg_tag;
    logic [NREQ-1:0][1:0][64:0]     r_fifo_data;
    logic [NREQ-1:0][1:0][TAGW-1:0] r_fifo_tag;
    logic [NREQ-1:0]                r_wr_ptr;
    logic [NREQ-1:0]                r_rd_ptr;
    logic [NREQ-1:0][1:0]           r_cnt;

    logic [NREQ-1:0]      w_elig;
    logic [NREQ-1:0]      w_gnt;
    logic                 w_any;
    logic [PW-1:0]        w_gnt_idx;
    logic [64:0]          w_sel_a;
    logic [64:0]          w_sel_b;
    logic [TAGW-1:0]      w_sel_tag;
    logic                 w_cap;
    logic [PW-1:0]        w_cap_port;
    logic [NREQ-1:0]      w_push;
    logic [NREQ-1:0]      w_pop;
    logic [NREQ-1:0]      w_res_vld;
    logic [NREQ*65-1:0]   w_res_data;
    logic [NREQ*TAGW-1:0] w_res_tag;

    // First eligible port scanning upward from the round-robin pointer.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_elig[i] = bus.req_vld[i] && (r_credit[i] != 2'd0) && !bus.flush[i];
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_any && w_elig[wrap_inc(r_rr, k)]) begin
                w_any     = 1'b1;
                w_gnt_idx = wrap_inc(r_rr, k);
            end
        end
        if (rst) w_any = 1'b0;
        w_gnt = '0;
        if (w_any) w_gnt[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_tag = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a   = bus.req_A[i*65 +: 65];
                w_sel_b   = bus.req_B[i*65 +: 65];
                w_sel_tag = bus.req_tag[i*TAGW +: TAGW];
            end
        end
    end

    // A flush in the capture cycle drops the result along with the rest of the port's work.
    assign w_cap_port = r_stg_port[LAT];
    assign w_cap      = r_stg_vld[LAT] && !bus.flush[w_cap_port] && !rst;

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_push[i] = w_cap && (w_cap_port == PW'(i));
            w_pop[i]  = (r_cnt[i] != 2'd0) && bus.res_ack[i] && !bus.flush[i] && !rst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr        <= '0;
            r_bnd_a     <= '0;
            r_bnd_b     <= '0;
            r_stg_vld   <= '0;
            r_stg_port  <= '0;
            r_stg_tag   <= '0;
            r_fifo_data <= '0;
            r_fifo_tag  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                r_credit[i] <= 2'd2;
            end
        end else begin
            if (w_any) begin
                r_rr    <= wrap_inc(w_gnt_idx, 1);
                r_bnd_a <= w_sel_a;
                r_bnd_b <= w_sel_b;
            end
            r_stg_vld[0]  <= w_any;
            r_stg_port[0] <= w_gnt_idx;
            r_stg_tag[0]  <= w_sel_tag;
            for (int unsigned k = 1; k <= LAT; k++) begin
                r_stg_vld[k]  <= r_stg_vld[k-1] && !bus.flush[r_stg_port[k-1]];
                r_stg_port[k] <= r_stg_port[k-1];
                r_stg_tag[k]  <= r_stg_tag[k-1];
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (bus.flush[i]) begin
                    r_credit[i] <= 2'd2;
                    r_cnt[i]    <= 2'd0;
                    r_wr_ptr[i] <= 1'b0;
                    r_rd_ptr[i] <= 1'b0;
                end else begin
                    if (w_gnt[i] && !w_pop[i]) begin
                        r_credit[i] <= r_credit[i] - 2'd1;
                    end else if (!w_gnt[i] && w_pop[i]) begin
                        r_credit[i] <= r_credit[i] + 2'd1;
                    end
                    if (w_push[i]) begin
                        r_fifo_data[i][r_wr_ptr[i]] <= bus.bnd_C;
                        r_fifo_tag[i][r_wr_ptr[i]]  <= r_stg_tag[LAT];
                        r_wr_ptr[i]                 <= ~r_wr_ptr[i];
                    end
                    if (w_pop[i]) r_rd_ptr[i] <= ~r_rd_ptr[i];
                    r_cnt[i] <= r_cnt[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
                end
            end
        end
    end

    always_comb begin
        w_res_vld  = '0;
        w_res_data = '0;
        w_res_tag  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!rst && (r_cnt[i] != 2'd0)) begin
                w_res_vld[i]              = 1'b1;
                w_res_data[i*65 +: 65]    = r_fifo_data[i][r_rd_ptr[i]];
                w_res_tag[i*TAGW +: TAGW] = r_fifo_tag[i][r_rd_ptr[i]];
            end
        end
    end

    assign bus.req_rdy  = w_gnt;
    assign bus.bnd_A    = r_bnd_a;
    assign bus.bnd_B    = r_bnd_b;
    assign bus.res_vld  = w_res_vld;
    assign bus.res_data = w_res_data;
    assign bus.res_tag  = w_res_tag;
    assign bus.idle     = rst || ((r_stg_vld == '0) && (r_cnt == '0));
endmodule

// File: tb/tb_bnd_sched.sv
// Bench for bnd_sched: directed scenarios then random traffic, every cycle compared
// against a transaction-level model of grants, credits, in-flight work and result queues.
module tb_bnd_sched;
    localparam int unsigned NREQ = 3;
    localparam int unsigned TAGW = 4;
    localparam int unsigned LAT  = 3;

    logic clk = 1'b0;
    logic rst;

    bnd_sched_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

    bnd_sched #(.NREQ(NREQ), .TAGW(TAGW), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] bnd_f(input logic [64:0] a, input logic [64:0] b);
        return a + b;
    endfunction

    // Behavioural bnd unit: result appears LAT cycles after the operands.
    logic [64:0] c_pipe [LAT];
    always @(posedge clk) begin
        c_pipe[0] <= bnd_f(bus.bnd_A, bus.bnd_B);
        for (int k = 1; k < int'(LAT); k++) c_pipe[k] <= c_pipe[k-1];
    end
    assign bus.bnd_C = c_pipe[LAT-1];

    typedef struct {
        int              port;
        logic [TAGW-1:0] tag;
        logic [64:0]     data;
        int              ready;
    } fl_t;

    typedef struct {
        int              port;
        logic [TAGW-1:0] tag;
        logic [64:0]     data;
    } rs_t;

    fl_t         infl[$];
    rs_t         rq[$];
    int          m_credit [NREQ];
    int          m_rr;
    logic [64:0] m_ba;
    logic [64:0] m_bb;
    bit          m_known;
    int          g_cur;
    int          cyc;
    int          n_assert;
    int          n_fail;
    logic [64:0] a0, b0, s0;
    int          ngr;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [64:0] rnd65();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[64:0];
    endfunction

    function automatic int head_idx(input int p);
        for (int j = 0; j < rq.size(); j++) if (rq[j].port == p) return j;
        return -1;
    endfunction

    task automatic set_req(input int p, input logic [64:0] a, input logic [64:0] b,
                           input logic [TAGW-1:0] tg);
        bus.req_vld[p]               = 1'b1;
        bus.req_A[p*65 +: 65]        = a;
        bus.req_B[p*65 +: 65]        = b;
        bus.req_tag[p*TAGW +: TAGW]  = tg;
    endtask

    task automatic set_rnd_req(input int p);
        set_req(p, rnd65(), rnd65(), TAGW'($urandom_range(0, 15)));
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic settle();
        logic [NREQ-1:0]      e_rdy;
        logic [NREQ-1:0]      e_vld;
        logic [NREQ*65-1:0]   e_data;
        logic [NREQ*TAGW-1:0] e_tag;
        logic                 e_idle;
        int                   h;
        #1;
        g_cur = -1;
        if (!rst) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                int p;
                p = (m_rr + k) % int'(NREQ);
                if (g_cur < 0 && bus.req_vld[p] && m_credit[p] > 0 && !bus.flush[p]) g_cur = p;
            end
        end
        e_rdy = '0;
        if (g_cur >= 0) e_rdy[g_cur] = 1'b1;
        e_vld  = '0;
        e_data = '0;
        e_tag  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            h = head_idx(i);
            if (!rst && h >= 0) begin
                e_vld[i]                  = 1'b1;
                e_data[i*65 +: 65]        = rq[h].data;
                e_tag[i*TAGW +: TAGW]     = rq[h].tag;
            end
        end
        e_idle = rst || (infl.size() == 0 && rq.size() == 0);
        chk("req_rdy", bus.req_rdy, e_rdy);
        chk("res_vld", bus.res_vld, e_vld);
        chk("res_data", bus.res_data, e_data);
        chk("res_tag", bus.res_tag, e_tag);
        chk("idle", bus.idle, e_idle);
        if (m_known) begin
            chk("bnd_A", bus.bnd_A, m_ba);
            chk("bnd_B", bus.bnd_B, m_bb);
        end
    endtask

    // Apply this cycle's clock edge to the model, then move to the next cycle.
    task automatic adv();
        int h;
        if (rst) begin
            infl.delete();
            rq.delete();
            m_rr = 0;
            for (int i = 0; i < int'(NREQ); i++) m_credit[i] = 2;
            m_ba    = '0;
            m_bb    = '0;
            m_known = 1'b1;
        end else begin
            if (g_cur >= 0) begin
                fl_t e;
                e.port  = g_cur;
                e.tag   = bus.req_tag[g_cur*TAGW +: TAGW];
                e.data  = bnd_f(bus.req_A[g_cur*65 +: 65], bus.req_B[g_cur*65 +: 65]);
                e.ready = cyc + int'(LAT) + 2;
                infl.push_back(e);
                m_credit[g_cur]--;
                m_ba = bus.req_A[g_cur*65 +: 65];
                m_bb = bus.req_B[g_cur*65 +: 65];
                m_rr = (g_cur + 1) % int'(NREQ);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                h = head_idx(i);
                if (bus.flush[i]) begin
                    m_credit[i] = 2;
                    for (int j = infl.size() - 1; j >= 0; j--) if (infl[j].port == i) infl.delete(j);
                    for (int j = rq.size() - 1; j >= 0; j--) if (rq[j].port == i) rq.delete(j);
                end else if (h >= 0 && bus.res_ack[i]) begin
                    rq.delete(h);
                    m_credit[i]++;
                end
            end
            while (infl.size() > 0 && infl[0].ready == cyc + 1) begin
                rs_t r;
                r.port = infl[0].port;
                r.tag  = infl[0].tag;
                r.data = infl[0].data;
                rq.push_back(r);
                void'(infl.pop_front());
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        m_known  = 1'b0;
        m_rr     = 0;
        m_ba     = '0;
        m_bb     = '0;
        for (int i = 0; i < int'(NREQ); i++) m_credit[i] = 2;
        rst         = 1'b1;
        bus.req_vld = '0;
        bus.req_A   = '0;
        bus.req_B   = '0;
        bus.req_tag = '0;
        bus.flush   = '0;
        bus.res_ack = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single port-0 request with tag 5: operands next cycle, result 5 cycles after grant.
        a0 = rnd65();
        b0 = rnd65();
        s0 = a0 + b0;
        set_req(0, a0, b0, 4'd5);
        settle(); chk("s1_grant", bus.req_rdy, 3'b001); adv();
        bus.req_vld = '0;
        settle(); chk("s1_bnd_a", bus.bnd_A, a0); chk("s1_bnd_b", bus.bnd_B, b0); adv();
        tick();
        tick();
        settle(); chk("s1_early", bus.res_vld[0], 1'b0); adv();
        bus.res_ack = 3'b001;
        settle();
        chk("s1_vld", bus.res_vld[0], 1'b1);
        chk("s1_tag", bus.res_tag[3:0], 4'd5);
        chk("s1_data", bus.res_data[64:0], s0);
        adv();
        bus.res_ack = '0;
        tick();

        // All ports requesting from reset with ack held high: grants rotate 0,1,2,...
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.res_ack = '1;
        for (int k = 0; k < 18; k++) begin
            logic [2:0] eg;
            eg = 3'b001 << (k % 3);
            for (int p = 0; p < int'(NREQ); p++) set_rnd_req(p);
            settle();
            if (k < 6) chk("rr_seq", bus.req_rdy, eg);
            adv();
        end
        bus.req_vld = '0;
        for (int k = 0; k < 8; k++) tick();

        // Port 1 without acks: exactly two grants, then a regrant only after an ack.
        bus.res_ack = '0;
        ngr = 0;
        for (int k = 0; k < 10; k++) begin
            set_rnd_req(1);
            settle();
            ngr += int'(bus.req_rdy[1]);
            adv();
        end
        chk("p1_two_grants", ngr, 2);
        chk("p1_fifo_full_vld", bus.res_vld[1], 1'b1);
        bus.res_ack = 3'b010;
        settle(); chk("p1_ack_cycle", bus.req_rdy[1], 1'b0); adv();
        bus.res_ack = '0;
        settle(); chk("p1_regrant", bus.req_rdy[1], 1'b1); adv();
        bus.req_vld = '0;
        bus.res_ack = '1;
        for (int k = 0; k < 10; k++) tick();

        // Port 2 issues twice, flushed in flight; credits restored immediately.
        bus.res_ack = '0;
        set_rnd_req(2);
        settle(); chk("p2_grant0", bus.req_rdy, 3'b100); adv();
        set_rnd_req(2);
        settle(); chk("p2_grant1", bus.req_rdy, 3'b100); adv();
        bus.req_vld = '0;
        tick();
        bus.flush = 3'b100;
        tick();
        bus.flush = '0;
        set_rnd_req(2);
        settle(); chk("p2_post_flush_grant", bus.req_rdy, 3'b100); adv();
        bus.req_vld = '0;
        for (int k = 0; k < 4; k++) begin
            settle(); chk("p2_no_result", bus.res_vld[2], 1'b0); adv();
        end
        bus.res_ack = '1;
        for (int k = 0; k < 4; k++) tick();

        // Reset with three operations in flight discards them all.
        bus.res_ack = '0;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < int'(NREQ); p++) set_rnd_req(p);
            tick();
        end
        bus.req_vld = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("rst_idle", bus.idle, 1'b1);
            chk("rst_no_res", bus.res_vld, 3'b000);
            adv();
        end

        // Port 0 at credit 1: same-cycle ack and grant keeps the credit, order preserved.
        set_req(0, rnd65(), rnd65(), 4'd1);
        tick();
        bus.req_vld = '0;
        for (int k = 0; k < 4; k++) tick();
        set_req(0, rnd65(), rnd65(), 4'd2);
        bus.res_ack = 3'b001;
        settle(); chk("c1_grant_ack", bus.req_rdy, 3'b001); adv();
        set_req(0, rnd65(), rnd65(), 4'd3);
        bus.res_ack = '0;
        settle(); chk("c1_grant_again", bus.req_rdy, 3'b001); adv();
        settle(); chk("c1_no_credit", bus.req_rdy, 3'b000); adv();
        bus.req_vld = '0;
        tick();
        tick();
        settle(); chk("c1_head_first", bus.res_tag[3:0], 4'd2); adv();
        bus.res_ack = 3'b001;
        settle(); chk("c1_head_still", bus.res_tag[3:0], 4'd2); adv();
        settle(); chk("c1_head_second", bus.res_tag[3:0], 4'd3); adv();
        tick();

        // Random traffic with occasional flushes and resets.
        for (int t = 0; t < 300; t++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < int'(NREQ); p++) begin
                if ($urandom_range(0, 1) == 1) set_rnd_req(p);
                else bus.req_vld[p] = 1'b0;
                bus.flush[p]   = ($urandom_range(0, 19) == 0);
                bus.res_ack[p] = ($urandom_range(0, 9) < 7);
            end
            tick();
        end
        rst         = 1'b0;
        bus.req_vld = '0;
        bus.flush   = '0;
        bus.res_ack = '1;
        for (int k = 0; k < 12; k++) tick();
        settle(); chk("drain_idle", bus.idle, 1'b1); adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
